// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue stage: aluop, funct and ALU control codes,
// plus the issue bundle layout and the operand forwarding mux.
package alu_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned ALUOP_W = 2;
    localparam int unsigned CTL_W   = 3;

    typedef enum logic [ALUOP_W-1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_OR    = 2'b11
    } aluop_e;

    typedef enum logic [CTL_W-1:0] {
        CTL_ADD = 3'b000,
        CTL_SUB = 3'b001,
        CTL_OR  = 3'b010,
        CTL_AND = 3'b110,
        CTL_SLT = 3'b111
    } alu_ctl_e;

    localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'b101010;

    typedef struct packed {
        alu_ctl_e            control;
        logic [DATA_W-1:0]   data_a;
        logic [DATA_W-1:0]   data_b;
        logic [REG_W-1:0]    rd;
        logic                illegal;
    } issue_t;

    // EX/MEM is the younger producer so it wins over MEM/WB; r0 is hardwired zero.
    function automatic logic [DATA_W-1:0] fwd_operand(
        input logic [REG_W-1:0]  spec,
        input logic [DATA_W-1:0] rf_val,
        input logic              ex_wr,
        input logic [REG_W-1:0]  ex_rd,
        input logic [DATA_W-1:0] ex_val,
        input logic              wb_wr,
        input logic [REG_W-1:0]  wb_rd,
        input logic [DATA_W-1:0] wb_val
    );
        logic [DATA_W-1:0] res;
        res = rf_val;
        if (spec != REG_W'(0)) begin
            if (ex_wr && (ex_rd == spec)) begin
                res = ex_val;
            end else if (wb_wr && (wb_rd == spec)) begin
                res = wb_val;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Issue-stage bus: decode slot handshake, forwarding sources and the ALU issue bundle.
interface alu_issue_stage_if;
    import alu_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [ALUOP_W-1:0]    in_aluop;
    logic [FUNCT_W-1:0]    in_funct;
    logic [REG_W-1:0]      in_rs;
    logic [REG_W-1:0]      in_rt;
    logic [REG_W-1:0]      in_rd;
    logic [DATA_W-1:0]     in_rs_val;
    logic [DATA_W-1:0]     in_rt_val;
    logic [DATA_W-1:0]     in_imm;
    logic                  in_alusrc;
    logic                  exmem_wr;
    logic [REG_W-1:0]      exmem_rd;
    logic [DATA_W-1:0]     exmem_val;
    logic                  memwb_wr;
    logic [REG_W-1:0]      memwb_rd;
    logic [DATA_W-1:0]     memwb_val;
    logic                  flush;
    logic                  out_ready;
    logic                  out_valid;
    logic [CTL_W-1:0]      control;
    logic [DATA_W-1:0]     dataA;
    logic [DATA_W-1:0]     dataB;
    logic [REG_W-1:0]      out_rd;
    logic                  out_illegal;

    modport master (
        output in_valid, in_aluop, in_funct, in_rs, in_rt, in_rd,
               in_rs_val, in_rt_val, in_imm, in_alusrc,
               exmem_wr, exmem_rd, exmem_val, memwb_wr, memwb_rd, memwb_val,
               flush, out_ready,
        input  in_ready, out_valid, control, dataA, dataB, out_rd, out_illegal
    );

    modport slave (
        input  in_valid, in_aluop, in_funct, in_rs, in_rt, in_rd,
               in_rs_val, in_rt_val, in_imm, in_alusrc,
               exmem_wr, exmem_rd, exmem_val, memwb_wr, memwb_rd, memwb_val,
               flush, out_ready,
        output in_ready, out_valid, control, dataA, dataB, out_rd, out_illegal
    );

endinterface

// File: rtl/alu_ctl_decode.sv
// Combinational aluop/funct to ALU control decode; unknown R-type funct flags illegal.
module alu_ctl_decode
    import alu_pkg::*;
(
    input  logic [ALUOP_W-1:0] aluop,
    input  logic [FUNCT_W-1:0] funct,
    output alu_ctl_e           control_c,
    output logic               illegal_c
);

    always_comb begin
        control_c = CTL_ADD;
        illegal_c = 1'b0;
        case (aluop)
            ALUOP_ADD: control_c = CTL_ADD;
            ALUOP_SUB: control_c = CTL_SUB;
            ALUOP_OR:  control_c = CTL_OR;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: control_c = CTL_ADD;
                    FUNCT_SUB: control_c = CTL_SUB;
                    FUNCT_OR:  control_c = CTL_OR;
                    FUNCT_AND: control_c = CTL_AND;
                    FUNCT_SLT: control_c = CTL_SLT;
                    default:   illegal_c = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Single-entry ALU issue register: captures a decoded instruction, resolves
// operand forwarding at capture, and holds the bundle until the ALU consumes it.
module alu_issue_stage (
    input  logic             clock,
    input  logic             reset,
    alu_issue_stage_if.slave bus
);
    import alu_pkg::*;

    logic     valid_q, valid_d;
    issue_t   entry_q, entry_d;
    alu_ctl_e dec_ctl_c;
    logic     dec_illegal_c;
    logic     in_ready_c;
    logic     capture_c;
    logic [DATA_W-1:0] fwd_a_c, fwd_b_c;

    alu_ctl_decode u_ctl_decode (
        .aluop     (bus.in_aluop),
        .funct     (bus.in_funct),
        .control_c (dec_ctl_c),
        .illegal_c (dec_illegal_c)
    );

    // Flush frees the slot, so the stage stays ready while flushing.
    always_comb begin
        in_ready_c = !valid_q || bus.out_ready || bus.flush;
        capture_c  = bus.in_valid && in_ready_c && !bus.flush;
        fwd_a_c = fwd_operand(bus.in_rs, bus.in_rs_val,
                              bus.exmem_wr, bus.exmem_rd, bus.exmem_val,
                              bus.memwb_wr, bus.memwb_rd, bus.memwb_val);
        fwd_b_c = fwd_operand(bus.in_rt, bus.in_rt_val,
                              bus.exmem_wr, bus.exmem_rd, bus.exmem_val,
                              bus.memwb_wr, bus.memwb_rd, bus.memwb_val);
    end

    always_comb begin
        valid_d = valid_q;
        entry_d = entry_q;
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (capture_c) begin
            valid_d         = 1'b1;
            entry_d.control = dec_ctl_c;
            entry_d.data_a  = fwd_a_c;
            entry_d.data_b  = bus.in_alusrc ? bus.in_imm : fwd_b_c;
            entry_d.rd      = bus.in_rd;
            entry_d.illegal = dec_illegal_c;
        end else if (valid_q && bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            entry_q <= '0;
        end else begin
            valid_q <= valid_d;
            entry_q <= entry_d;
        end
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.out_valid   = valid_q;
    assign bus.control     = entry_q.control;
    assign bus.dataA       = entry_q.data_a;
    assign bus.dataB       = entry_q.data_b;
    assign bus.out_rd      = entry_q.rd;
    assign bus.out_illegal = entry_q.illegal;

endmodule
